sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 63 ++++++
 rtl/sram_arbiter.sv | 93 +++++++++
 tb/tb_sram_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-requester SRAM arbiter.
// Build option: define SRAM_ARBITER_FIXED_PRIO_EN for fixed priority (m0 always wins).
package sram_arbiter_pkg;

    // Arbitration state: names the requester served most recently.
    typedef enum logic {
        LAST_M0 = 1'b0,
        LAST_M1 = 1'b1
    } arb_state_e;

    // Which requester the response in flight belongs to.
    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input grant logic for sram_arbiter.
// Default build: round-robin FSM (LAST_M0 / LAST_M1).
// Build option SRAM_ARBITER_FIXED_PRIO_EN: fixed priority to input 0, no FSM.
// Grants are combinational from the requests and are forced low while rst_n is low.
module rr_arbiter2
    import sram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef SRAM_ARBITER_FIXED_PRIO_EN

    // Fixed priority: input 0 always wins, input 1 only gets the idle slots.
    always_comb begin
        gnt0 = rst_n & req0;
        gnt1 = rst_n & req1 & ~req0;
    end

`else

    arb_state_e state;
    arb_state_e state_next;

    // State register; reset leaves m1 as "last served" so m0 wins the first contention.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= LAST_M1;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and next state: the requester not named by the state wins a tie.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_next = state;
        if (rst_n) begin
            if (req0 && req1) begin
                gnt0 = (state == LAST_M1);
                gnt1 = (state == LAST_M0);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
            if (gnt0) begin
                state_next = LAST_M0;
            end else if (gnt1) begin
                state_next = LAST_M1;
            end
        end
    end

`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of port A of an sram_dualport (port B stays free).
// One access per cycle; every accepted access gets one rvalid pulse one cycle later.
// Build option: SRAM_ARBITER_FIXED_PRIO_EN selects fixed priority (m0 always wins).
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int ADDRWIDTH    = 14,
    parameter int BYTE_ENABLES = DATAWIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req,
    output logic                    m0_gnt,
    input  logic [ADDRWIDTH-1:0]    m0_addr,
    input  logic                    m0_we,
    input  logic [BYTE_ENABLES-1:0] m0_be,
    input  logic [DATAWIDTH-1:0]    m0_wdata,
    output logic                    m0_rvalid,
    output logic [DATAWIDTH-1:0]    m0_rdata,

    input  logic                    m1_req,
    output logic                    m1_gnt,
    input  logic [ADDRWIDTH-1:0]    m1_addr,
    input  logic                    m1_we,
    input  logic [BYTE_ENABLES-1:0] m1_be,
    input  logic [DATAWIDTH-1:0]    m1_wdata,
    output logic                    m1_rvalid,
    output logic [DATAWIDTH-1:0]    m1_rdata,

    output logic [ADDRWIDTH-1:0]    sram_addr,
    output logic                    sram_we,
    output logic [BYTE_ENABLES-1:0] sram_be,
    output logic [DATAWIDTH-1:0]    sram_d,
    input  logic [DATAWIDTH-1:0]    sram_q
);

    logic   gnt0;
    logic   gnt1;
    logic   rvalid_q;
    owner_e owner_q;
    logic   rsp_live;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (m0_req),
        .req1  (m1_req),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Steer the granted requester onto SRAM port A; no grant means no write.
    always_comb begin
        sram_addr = m0_addr;
        sram_be   = m0_be;
        sram_d    = m0_wdata;
        sram_we   = 1'b0;
        if (gnt1) begin
            sram_addr = m1_addr;
            sram_be   = m1_be;
            sram_d    = m1_wdata;
            sram_we   = m1_we;
        end else if (gnt0) begin
            sram_we   = m0_we;
        end
    end

    // Response tracking: one pulse per grant, tagged with the requester that was served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            owner_q  <= OWNER_M0;
        end else begin
            rvalid_q <= gnt0 | gnt1;
            if (gnt0 || gnt1) begin
                owner_q <= gnt1 ? OWNER_M1 : OWNER_M0;
            end
        end
    end

    // A response still in flight when reset arrives is dropped, so rvalid is gated by rst_n.
    assign rsp_live  = rvalid_q & rst_n;
    assign m0_rvalid = rsp_live & (owner_q == OWNER_M0);
    assign m1_rvalid = rsp_live & (owner_q == OWNER_M1);
    assign m0_rdata  = m0_rvalid ? sram_q : '0;
    assign m1_rdata  = m1_rvalid ? sram_q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural SRAM on port A.
// The reference model predicts grants from the arbitration rules and read data from a
// shadow memory of everything the requesters were allowed to write.
// Build option SRAM_ARBITER_FIXED_PRIO_EN switches the expected arbitration to fixed priority.
module tb_sram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [13:0] m0_addr, m1_addr;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [13:0] sram_addr;
    logic        sram_we;
    logic [3:0]  sram_be;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    int checks = 0;
    int fails  = 0;

    sram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_gnt    (m0_gnt),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_be     (m0_be),
        .m0_wdata  (m0_wdata),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_gnt    (m1_gnt),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_be     (m1_be),
        .m1_wdata  (m1_wdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_be   (sram_be),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural SRAM port A: byte-lane writes, one-cycle read latency, preload port.
    bit   [31:0] sram_mem [0:16383];
    logic        preload_en;
    logic [13:0] preload_addr;
    logic [31:0] preload_data;

    always @(posedge clk) begin
        if (preload_en) sram_mem[preload_addr] <= preload_data;
        else if (sram_we) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_d, sram_be);
        sram_q <= sram_mem[sram_addr];
    end

    // Reference model state.
    bit   [31:0] exp_mem [0:16383];
    int          last_served;      // 0 or 1: requester served most recently
    bit          pend_valid;
    int          pend_owner;
    bit          pend_read;
    logic [31:0] pend_data;

    logic        exp_g0, exp_g1, exp_sram_we, exp_rv0, exp_rv1;
    logic [13:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;

    always_comb begin
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (rst_n) begin
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
            exp_g0 = m0_req;
            exp_g1 = m1_req && !m0_req;
`else
            if (m0_req && m1_req) begin
                exp_g0 = (last_served == 1);
                exp_g1 = (last_served == 0);
            end else begin
                exp_g0 = m0_req;
                exp_g1 = m1_req;
            end
`endif
        end
        exp_addr    = exp_g1 ? m1_addr  : m0_addr;
        exp_be      = exp_g1 ? m1_be    : m0_be;
        exp_wdata   = exp_g1 ? m1_wdata : m0_wdata;
        exp_sram_we = (exp_g0 && m0_we) || (exp_g1 && m1_we);
        exp_rv0     = rst_n && pend_valid && (pend_owner == 0);
        exp_rv1     = rst_n && pend_valid && (pend_owner == 1);
    end

    always @(posedge clk) begin
        if (preload_en) exp_mem[preload_addr] <= preload_data;
        if (!rst_n) begin
            last_served <= 1;
            pend_valid  <= 1'b0;
        end else begin
            pend_valid <= exp_g0 || exp_g1;
            if (exp_g0 || exp_g1) begin
                pend_owner  <= exp_g1 ? 1 : 0;
                pend_read   <= !exp_sram_we;
                pend_data   <= exp_mem[exp_addr];
                last_served <= exp_g1 ? 1 : 0;
                if (exp_sram_we) exp_mem[exp_addr] <= merge(exp_mem[exp_addr], exp_wdata, exp_be);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        tick();
        preload_en   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== 2'b00) begin
                fails++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
            end
            checks++;
            if ({m0_rvalid, m1_rvalid, sram_we} !== 3'b000) begin
                fails++; $display("FAIL reset_rvalid_we: got %b expected 000", {m0_rvalid, m1_rvalid, sram_we});
            end
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h10;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, sram_we, sram_addr} !== {3'b100, 14'h10}) begin
            fails++; $display("FAIL single_read_grant: got %b_%h expected 100_0010", {m0_gnt, m1_gnt, sram_we}, sram_addr);
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10) begin
            fails++; $display("FAIL single_read_rvalid: got %b expected 10", {m0_rvalid, m1_rvalid});
        end
        checks++;
        if (m0_rdata !== 32'hDEADBEEF || m1_rdata !== 32'h0) begin
            fails++; $display("FAIL single_read_rdata: got %h/%h expected deadbeef/00000000", m0_rdata, m1_rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] want, prev;
        apply_reset();
        prev = 2'b00;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            m0_addr = 14'($urandom_range(0, 15));
            m1_addr = 14'($urandom_range(0, 15));
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
            want = (i < 4) ? 2'b10 : 2'b00;
`else
            want = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b10 : 2'b01);
`endif
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== want) begin
                fails++; $display("FAIL rr_gnt cycle %0d: got %b expected %b", i, {m0_gnt, m1_gnt}, want);
            end
            checks++;
            if ({m0_rvalid, m1_rvalid} !== prev) begin
                fails++; $display("FAIL rr_rvalid cycle %0d: got %b expected %b", i, {m0_rvalid, m1_rvalid}, prev);
            end
            if (prev != 2'b00) begin
                checks++;
                if ((prev[1] ? m0_rdata : m1_rdata) !== pend_data) begin
                    fails++; $display("FAIL rr_rdata cycle %0d: got %h expected %h", i, prev[1] ? m0_rdata : m1_rdata, pend_data);
                end
            end
            prev = want;
            tick();
        end
    endtask

    task automatic test_byte_write();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 14'h20; m1_be = 4'b0101; m1_wdata = 32'h11223344;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, sram_we, sram_be, sram_d, sram_addr} !== {3'b011, 4'b0101, 32'h11223344, 14'h20}) begin
            fails++; $display("FAIL byte_write_port: got %b be=%b d=%h a=%h expected 011 be=0101 d=11223344 a=0020",
                              {m0_gnt, m1_gnt, sram_we}, sram_be, sram_d, sram_addr);
        end
        tick();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h20; m0_be = 4'b0000;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1001) begin
            fails++; $display("FAIL byte_write_rsp: got %b expected 1001", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAA22AA44) begin
            fails++; $display("FAIL byte_write_readback: got v=%b %h expected v=1 aa22aa44", m0_rvalid, m0_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 14'h3; m0_be = 4'hF; m0_wdata = 32'h5;
        @(negedge clk);
        checks++;
        if ({m0_gnt, sram_we} !== 2'b11) begin
            fails++; $display("FAIL b2b_write_gnt: got %b expected 11", {m0_gnt, sram_we});
        end
        tick();
        m0_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_gnt, sram_we, m0_rvalid} !== 3'b101) begin
            fails++; $display("FAIL b2b_read_gnt: got %b expected 101", {m0_gnt, sram_we, m0_rvalid});
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h5) begin
            fails++; $display("FAIL b2b_readback: got v=%b %h expected v=1 00000005", m0_rvalid, m0_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0) begin
            fails++; $display("FAIL b2b_single_pulse: got %b expected 0", m0_rvalid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h10;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            fails++; $display("FAIL rst_mid_gnt: got %b expected 01", {m0_gnt, m1_gnt});
        end
        tick();
        m1_req = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
            fails++; $display("FAIL rst_mid_dropped: got %b expected 00", {m0_rvalid, m1_rvalid});
        end
        tick();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h10;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m1_rvalid} !== 3'b100) begin
            fails++; $display("FAIL rst_mid_first: got %b expected 100", {m0_gnt, m1_gnt, m1_rvalid});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== {exp_g0, exp_g1}) begin
            fails++; $display("FAIL rst_mid_second: got %b expected %b", {m0_gnt, m1_gnt}, {exp_g0, exp_g1});
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

`ifdef SRAM_ARBITER_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m0_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt} !== ((i < 3) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL fixed_prio cycle %0d: got %b", i, {m0_gnt, m1_gnt});
            end
            tick();
        end
        m1_req = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m0_we    = 1'($urandom_range(0, 1));
            m1_we    = 1'($urandom_range(0, 1));
            m0_addr  = 14'($urandom_range(0, 15));
            m1_addr  = 14'($urandom_range(0, 15));
            m0_be    = 4'($urandom);
            m1_be    = 4'($urandom);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, sram_we} !== {exp_g0, exp_g1, exp_sram_we}) begin
                fails++; $display("FAIL rand_gnt cycle %0d: got %b expected %b", i,
                                  {m0_gnt, m1_gnt, sram_we}, {exp_g0, exp_g1, exp_sram_we});
            end
            if (exp_sram_we) begin
                checks++;
                if ({sram_addr, sram_be, sram_d} !== {exp_addr, exp_be, exp_wdata}) begin
                    fails++; $display("FAIL rand_port cycle %0d: got %h/%b/%h expected %h/%b/%h", i,
                                      sram_addr, sram_be, sram_d, exp_addr, exp_be, exp_wdata);
                end
            end
            checks++;
            if ({m0_rvalid, m1_rvalid} !== {exp_rv0, exp_rv1}) begin
                fails++; $display("FAIL rand_rvalid cycle %0d: got %b expected %b", i,
                                  {m0_rvalid, m1_rvalid}, {exp_rv0, exp_rv1});
            end
            if (exp_rv0 || exp_rv1) begin
                checks++;
                if ((exp_rv0 ? m1_rdata : m0_rdata) !== 32'h0) begin
                    fails++; $display("FAIL rand_nonowner cycle %0d: got %h expected 0", i,
                                      exp_rv0 ? m1_rdata : m0_rdata);
                end
                if (pend_read) begin
                    checks++;
                    if ((exp_rv0 ? m0_rdata : m1_rdata) !== pend_data) begin
                        fails++; $display("FAIL rand_rdata cycle %0d: got %h expected %h", i,
                                          exp_rv0 ? m0_rdata : m1_rdata, pend_data);
                    end
                end
            end
            tick();
        end
        rst_n  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
        preload_en = 1'b0; preload_addr = '0; preload_data = '0;
        tick();
        preload(14'h10, 32'hDEADBEEF);
        preload(14'h20, 32'hAAAAAAAA);
        test_reset();
        test_single_read();
        test_round_robin();
        test_byte_write();
        test_back_to_back();
        test_reset_mid();
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
